// File: rtl/apb_cmd_pkg.sv
// Shared definitions for the APB command master: FSM encoding, the
// address alignment mask and the response error-cause codes.
package apb_cmd_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Why a response carries RSP_ERR (NONE when it does not)
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SLVERR  = 2'd1,
        CAUSE_ALIGN   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } rsp_cause_e;

    // True when the byte address is not word aligned
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus signals of the command master.
//
// Handshake rule for both streams: a transfer happens on the rising
// clock edge where VALID and READY are both 1. The producer keeps VALID
// and its payload stable until that edge; READY may change freely and
// never depends combinationally on VALID.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command stream
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [DATA_W-1:0] CMD_WDATA;
    // Response stream
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              RSP_TIMEOUT;
    // APB3 bus
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    // View of the requester (the command master itself)
    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
        input  PREADY, PSLVERR, PRDATA,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    // View of the environment: command source, response sink, APB slave
    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
        output PREADY, PSLVERR, PRDATA,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-phase wait counter. Flags expiry when the count
// reaches TIMEOUT-1; never expires when TIMEOUT is 0.
module apb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               LIMIT_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LIMIT   = LIMIT_I[CNT_W-1:0];

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    // Count waited cycles; clear wins, and the count holds at all-ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_never
            assign o_expired = 1'b0;
        end else begin : g_limit
            assign o_expired = (r_count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns one valid/ready command into one APB transfer
// and returns one response. One transfer in flight; all outputs come
// straight from flops so reset clears the bus asynchronously.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    apb_cmd_master_if.master bus,
    output logic [1:0]       o_dbg_state
);

    logic [1:0]        r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;

    logic w_cmd_fire;
    logic w_misaligned;
    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_expired;

    assign w_cmd_fire   = r_cmd_ready && bus.CMD_VALID;
    assign w_misaligned = is_misaligned(bus.CMD_ADDR[1:0]);
    assign w_cnt_clear  = (r_state == ST_SETUP);
    assign w_cnt_enable = (r_state == ST_ACCESS) && !bus.PREADY;

    apb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    // Command FSM: accept, run SETUP/ACCESS, then hold the response
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_cmd_ready) begin
                        // first cycle out of reset: open the command port
                        r_cmd_ready <= 1'b1;
                    end else if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        if (w_misaligned) begin
                            // reject without touching the bus
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_rdata   <= '0;
                            r_state       <= ST_RESP;
                        end else begin
                            r_paddr  <= bus.CMD_ADDR;
                            r_pwrite <= bus.CMD_WRITE;
                            r_pwdata <= bus.CMD_WDATA;
                            r_psel   <= 1'b1;
                            r_state  <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so it beats a same-cycle timeout
                    if (bus.PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (w_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.CMD_READY   = r_cmd_ready;
    assign bus.RSP_VALID   = r_rsp_valid;
    assign bus.RSP_RDATA   = r_rsp_rdata;
    assign bus.RSP_ERR     = r_rsp_err;
    assign bus.RSP_TIMEOUT = r_rsp_timeout;
    assign bus.PADDR       = r_paddr;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus short random bench for apb_cmd_master with an APB slave
// model (programmable wait states, hang and error) and a response
// scoreboard queue.
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;
    localparam int EXP_W   = DATA_W + 2;
    localparam int BOUND   = 40;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] ref_mem [4] = '{32'h5A5A_5A5A, 32'h0, 32'h0, 32'h0000_1234};

    // ---------------- APB slave model ----------------
    logic [DATA_W-1:0] slv_mem [4] = '{32'h5A5A_5A5A, 32'h0, 32'h0, 32'h0000_1234};
    int   slv_wait = 0;
    logic slv_hang = 1'b0;
    logic slv_err  = 1'b0;
    int   acc_cnt  = 0;

    assign bus.PREADY  = bus.PSEL && bus.PENABLE && !slv_hang && (acc_cnt >= slv_wait);
    assign bus.PSLVERR = slv_err;
    assign bus.PRDATA  = bus.PREADY ? slv_mem[bus.PADDR[3:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else                                         acc_cnt <= 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !slv_err)
            slv_mem[bus.PADDR[3:2]] <= bus.PWDATA;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cause_bits(input rsp_cause_e c);
        case (c)
            CAUSE_NONE:    return 2'b00;
            CAUSE_SLVERR:  return 2'b10;
            CAUSE_ALIGN:   return 2'b10;
            default:       return 2'b11;
        endcase
    endfunction

    // Bus protocol monitor
    logic prev_psel = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.PENABLE) chk("pen_without_psel", bus.PSEL, 1);
            if (bus.PSEL && !prev_psel) chk("pen_in_first_psel", bus.PENABLE, 0);
            if (bus.PSEL) chk("psel_state", (dbg_state == ST_SETUP || dbg_state == ST_ACCESS), 1);
        end
        prev_psel = bus.PSEL;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input rsp_cause_e cause, input logic [31:0] rdata);
        int n = 0;
        while (bus.CMD_READY !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", (n < BOUND), 1);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = addr;
        bus.CMD_WDATA = wdata;
        exp_q.push_back({rdata, cause_bits(cause)});
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = $urandom_range(0, 1);
        bus.CMD_ADDR  = $urandom;
        bus.CMD_WDATA = $urandom;
        chk("cmd_ready_drop", bus.CMD_READY, 0);
    endtask

    task automatic count_access(output int pen);
        int n = 0;
        pen = 0;
        while (bus.RSP_VALID !== 1'b1 && n < BOUND) begin
            if (bus.PENABLE) pen++;
            @(negedge clk);
            n++;
        end
        chk("access_wait", (n < BOUND), 1);
    endtask

    task automatic collect(input string tag, input int hold);
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] got;
        int n = 0;
        while (bus.RSP_VALID !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_wait"}, (n < BOUND), 1);
        chk({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        got = {bus.RSP_RDATA, bus.RSP_ERR, bus.RSP_TIMEOUT};
        chk({tag, "_rdata"},   got[EXP_W-1:2], exp[EXP_W-1:2]);
        chk({tag, "_err"},     got[1], exp[1]);
        chk({tag, "_timeout"}, got[0], exp[0]);
        for (int k = 0; k < hold; k++) begin
            chk({tag, "_hold_valid"}, bus.RSP_VALID, 1);
            chk({tag, "_hold_fields"}, {bus.RSP_RDATA, bus.RSP_ERR, bus.RSP_TIMEOUT}, got);
            chk({tag, "_hold_cmd_ready"}, bus.CMD_READY, 0);
            @(negedge clk);
        end
        bus.RSP_READY = 1'b1;
        @(negedge clk);
        bus.RSP_READY = 1'b0;
        chk({tag, "_valid_drop"}, bus.RSP_VALID, 0);
        chk({tag, "_cmd_ready_back"}, bus.CMD_READY, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pen;
        logic        wr;
        int          idx;
        logic [31:0] data;

        rst           = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.CMD_READY, 0);
        chk("rst_rsp_valid", bus.RSP_VALID, 0);
        chk("rst_rsp_fields", {bus.RSP_RDATA, bus.RSP_ERR, bus.RSP_TIMEOUT}, 0);
        chk("rst_apb", {bus.PADDR, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PWDATA}, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.CMD_READY, 1);

        // Zero-wait write with cycle-exact phase checks
        slv_wait = 0;
        issue(1'b1, 32'h4, 32'h0000_A003, CAUSE_NONE, 32'h0);
        ref_mem[1] = 32'h0000_A003;
        chk("wr_setup_psel", bus.PSEL, 1);
        chk("wr_setup_pen", bus.PENABLE, 0);
        chk("wr_setup_paddr", bus.PADDR, 32'h4);
        chk("wr_setup_pwdata", bus.PWDATA, 32'h0000_A003);
        chk("wr_setup_pwrite", bus.PWRITE, 1);
        @(negedge clk);
        chk("wr_access_psel", bus.PSEL, 1);
        chk("wr_access_pen", bus.PENABLE, 1);
        chk("wr_access_paddr", bus.PADDR, 32'h4);
        chk("wr_access_pwdata", bus.PWDATA, 32'h0000_A003);
        @(negedge clk);
        chk("wr_rsp_latency", bus.RSP_VALID, 1);
        chk("wr_rsp_psel_low", bus.PSEL, 0);
        collect("wr4", 0);

        // Read back the written register
        issue(1'b0, 32'h4, 32'h0, CAUSE_NONE, 32'h0000_A003);
        collect("rd4", 0);

        // Read with 3 wait states
        slv_wait = 3;
        issue(1'b0, 32'h0, 32'h0, CAUSE_NONE, 32'h5A5A_5A5A);
        count_access(pen);
        chk("wait3_pen_cycles", pen, 4);
        collect("rd0_wait3", 0);

        // Misaligned read: no bus activity, response next cycle
        slv_wait = 0;
        issue(1'b0, 32'h2, 32'h0, CAUSE_ALIGN, 32'h0);
        chk("align_no_psel", bus.PSEL, 0);
        chk("align_rsp_latency", bus.RSP_VALID, 1);
        collect("align", 0);

        // Slave never answers: timeout after TIMEOUT access cycles
        slv_hang = 1'b1;
        issue(1'b0, 32'h8, 32'h0, CAUSE_TIMEOUT, 32'h0);
        count_access(pen);
        chk("timeout_pen_cycles", pen, TIMEOUT);
        chk("timeout_bus_idle", {bus.PSEL, bus.PENABLE}, 0);
        collect("timeout", 1);
        slv_hang = 1'b0;

        // Following command completes normally
        issue(1'b1, 32'h8, 32'h0000_0077, CAUSE_NONE, 32'h0);
        ref_mem[2] = 32'h0000_0077;
        collect("after_timeout_wr", 0);

        // PREADY on the same cycle as the timeout limit completes normally
        slv_wait = TIMEOUT - 1;
        issue(1'b0, 32'h8, 32'h0, CAUSE_NONE, 32'h0000_0077);
        count_access(pen);
        chk("limit_pen_cycles", pen, TIMEOUT);
        collect("limit_rd", 0);

        // Slave error on a read, response held for 5 cycles
        slv_wait = 0;
        slv_err  = 1'b1;
        issue(1'b0, 32'hC, 32'h0, CAUSE_SLVERR, 32'h0000_1234);
        collect("slverr_rd", 5);

        // Slave error on a write: data stays 0
        issue(1'b1, 32'hC, 32'hFFFF_FFFF, CAUSE_SLVERR, 32'h0);
        collect("slverr_wr", 2);
        slv_err = 1'b0;

        // Reset in the middle of an ACCESS phase
        slv_hang = 1'b1;
        issue(1'b0, 32'h0, 32'h0, CAUSE_NONE, 32'h5A5A_5A5A);
        @(negedge clk);
        chk("mid_rst_pen_before", bus.PENABLE, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_psel", bus.PSEL, 0);
        chk("mid_rst_pen", bus.PENABLE, 0);
        chk("mid_rst_rsp_valid", bus.RSP_VALID, 0);
        chk("mid_rst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        @(negedge clk);
        rst      = 1'b0;
        slv_hang = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", bus.CMD_READY, 1);
        for (int k = 0; k < 4; k++) begin
            chk("mid_rst_no_stale_rsp", bus.RSP_VALID, 0);
            @(negedge clk);
        end
        issue(1'b0, 32'h4, 32'h0, CAUSE_NONE, 32'h0000_A003);
        collect("after_rst_rd", 0);

        // Short random mix of aligned reads/writes with random wait states
        for (int i = 0; i < 10; i++) begin
            wr       = 1'($urandom_range(0, 1));
            idx      = $urandom_range(0, 3);
            data     = $urandom;
            slv_wait = $urandom_range(0, 3);
            if (wr) begin
                issue(1'b1, 32'(idx * 4), data, CAUSE_NONE, 32'h0);
                ref_mem[idx] = data;
            end else begin
                issue(1'b0, 32'(idx * 4), 32'h0, CAUSE_NONE, ref_mem[idx]);
            end
            collect("rnd", $urandom_range(0, 2));
        end

        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
